// File: rtl/exe_hazard_ctrl_if.sv
// Signal bundle between the front end and the EXE-stage hazard/forwarding controller.
// The front end is the master; exe_hazard_ctrl is the slave.
interface exe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_use_src2;
    logic              id_use_sval;
    logic [REG_AW-1:0] id_dest;
    logic              id_wb_en;
    logic              id_mem_read;
    logic              br_taken;

    logic [1:0]        val1_sel;
    logic [1:0]        val2_sel;
    logic [1:0]        src2_sel;
    logic              stall;
    logic              bubble;
    logic              flush;
    logic [1:0]        hz_state;

    modport master (
        output id_valid, id_src1, id_src2, id_use_src2, id_use_sval,
               id_dest, id_wb_en, id_mem_read, br_taken,
        input  val1_sel, val2_sel, src2_sel, stall, bubble, flush, hz_state
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use_src2, id_use_sval,
               id_dest, id_wb_en, id_mem_read, br_taken,
        output val1_sel, val2_sel, src2_sel, stall, bubble, flush, hz_state
    );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage hazard and forwarding controller: forwarding selects, load-use stalls, branch flushes.
// Define FORWARDING_EN to enable operand forwarding; otherwise every RAW dependency stalls.
module exe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input logic              clk,
    input logic              rst_n,
    exe_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        flush_cnt;

    // The WB stage is not tracked: the register file is write-through, so it never matters.
    logic [REG_AW-1:0] ex_dest;
    logic              ex_wb;
    logic              ex_mr;
    logic [REG_AW-1:0] mem_dest;
    logic              mem_wb;

    logic use_src2_any;
    logic dep_ex1, dep_ex2, dep_mem1, dep_mem2;
    logic data_hazard;
    logic stall_c, flush_c, bubble_c, issue;

    function automatic logic dep(input logic wb, input logic [REG_AW-1:0] dest,
                                 input logic [REG_AW-1:0] src);
        return wb && (dest == src) && (src != '0);
    endfunction

    function automatic logic [1:0] sel_of(input logic d_ex, input logic d_mem);
        return d_ex ? 2'd1 : (d_mem ? 2'd2 : 2'd0);
    endfunction

    always_comb begin
        use_src2_any = hz.id_use_src2 | hz.id_use_sval;
        dep_ex1      = dep(ex_wb, ex_dest, hz.id_src1);
        dep_ex2      = use_src2_any & dep(ex_wb, ex_dest, hz.id_src2);
        dep_mem1     = dep(mem_wb, mem_dest, hz.id_src1);
        dep_mem2     = use_src2_any & dep(mem_wb, mem_dest, hz.id_src2);
`ifdef FORWARDING_EN
        data_hazard  = hz.id_valid & ex_mr & (dep_ex1 | dep_ex2);
`else
        data_hazard  = hz.id_valid & (dep_ex1 | dep_ex2 | dep_mem1 | dep_mem2);
`endif
        // A taken branch kills the wrong-path ID instruction, so it outranks any stall.
        flush_c  = rst_n & ((state == FLUSH) | hz.br_taken);
        stall_c  = rst_n & (state != FLUSH) & ~hz.br_taken & data_hazard;
        bubble_c = flush_c | stall_c;
        issue    = hz.id_valid & ~stall_c & ~bubble_c;
    end

    assign hz.stall    = stall_c;
    assign hz.bubble   = bubble_c;
    assign hz.flush    = flush_c;
    assign hz.hz_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            flush_cnt <= 2'd0;
        end else begin
            case (state)
                RUN, STALL: begin
                    if (hz.br_taken) begin
                        if (FLUSH_CYCLES > 0) begin
                            state     <= FLUSH;
                            flush_cnt <= 2'(FLUSH_CYCLES - 1);
                        end else begin
                            state <= RUN;
                        end
                    end else if (stall_c) begin
                        state <= STALL;
                    end else begin
                        state <= RUN;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 2'd0) begin
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 2'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_dest     <= '0;
            ex_wb       <= 1'b0;
            ex_mr       <= 1'b0;
            mem_dest    <= '0;
            mem_wb      <= 1'b0;
            hz.val1_sel <= 2'd0;
            hz.val2_sel <= 2'd0;
            hz.src2_sel <= 2'd0;
        end else begin
            ex_dest  <= issue ? hz.id_dest : '0;
            ex_wb    <= issue & hz.id_wb_en;
            ex_mr    <= issue & hz.id_mem_read;
            mem_dest <= ex_dest;
            mem_wb   <= ex_wb;
`ifdef FORWARDING_EN
            hz.val1_sel <= issue ? sel_of(dep_ex1, dep_mem1) : 2'd0;
            hz.val2_sel <= (issue & hz.id_use_src2) ? sel_of(dep_ex2, dep_mem2) : 2'd0;
            hz.src2_sel <= (issue & hz.id_use_sval) ? sel_of(dep_ex2, dep_mem2) : 2'd0;
`else
            hz.val1_sel <= 2'd0;
            hz.val2_sel <= 2'd0;
            hz.src2_sel <= 2'd0;
`endif
        end
    end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed scoreboard bench for exe_hazard_ctrl (FLUSH_CYCLES = 1).
// Expectations follow FORWARDING_EN exactly as the design build does.
module tb_exe_hazard_ctrl;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    exe_hazard_ctrl_if #(.REG_AW(AW)) hz ();

    exe_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    typedef struct {
        logic [1:0] v1;
        logic [1:0] v2;
        logic [1:0] s2;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic checkOutput(input string tag, input logic [1:0] observed,
                               input logic [1:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One ID cycle: drive after the falling edge, check the combinational controls,
    // then check the flops latched by the rising edge against the queued expectation.
    task automatic applyStimulus(input string tag, input logic valid,
                                 input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                 input logic use2, input logic usev,
                                 input logic [AW-1:0] d, input logic wb, input logic mr,
                                 input logic br, input logic e_stall, input logic e_bubble,
                                 input logic e_flush, input logic [1:0] e_v1,
                                 input logic [1:0] e_v2, input logic [1:0] e_s2,
                                 input logic [1:0] e_st);
        exp_t e;
        @(negedge clk);
        hz.id_valid    = valid;
        hz.id_src1     = s1;
        hz.id_src2     = s2;
        hz.id_use_src2 = use2;
        hz.id_use_sval = usev;
        hz.id_dest     = d;
        hz.id_wb_en    = wb;
        hz.id_mem_read = mr;
        hz.br_taken    = br;
        sb.push_back('{v1: e_v1, v2: e_v2, s2: e_s2, st: e_st});
        #2;
        checkOutput({tag, ".stall"},  2'(hz.stall),  2'(e_stall));
        checkOutput({tag, ".bubble"}, 2'(hz.bubble), 2'(e_bubble));
        checkOutput({tag, ".flush"},  2'(hz.flush),  2'(e_flush));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({tag, ".val1_sel"}, hz.val1_sel, e.v1);
        checkOutput({tag, ".val2_sel"}, hz.val2_sel, e.v2);
        checkOutput({tag, ".src2_sel"}, hz.src2_sel, e.s2);
        checkOutput({tag, ".hz_state"}, hz.hz_state, e.st);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        hz.id_valid    = 1'b0;
        hz.id_src1     = '0;
        hz.id_src2     = '0;
        hz.id_use_src2 = 1'b0;
        hz.id_use_sval = 1'b0;
        hz.id_dest     = '0;
        hz.id_wb_en    = 1'b0;
        hz.id_mem_read = 1'b0;
        hz.br_taken    = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.stall",    2'(hz.stall),  2'd0);
        checkOutput("rst.bubble",   2'(hz.bubble), 2'd0);
        checkOutput("rst.flush",    2'(hz.flush),  2'd0);
        checkOutput("rst.val1_sel", hz.val1_sel,   2'd0);
        checkOutput("rst.val2_sel", hz.val2_sel,   2'd0);
        checkOutput("rst.src2_sel", hz.src2_sel,   2'd0);
        checkOutput("rst.hz_state", hz.hz_state,   2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain(2);

        // add r3,r1,r2 followed directly by sub r4,r3,r5
        applyStimulus("add_r3", 1, 1, 2, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
        applyStimulus("sub_b2b", 1, 3, 5, 1, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
`else
        applyStimulus("sub_stall1", 1, 3, 5, 1, 0, 4, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("sub_stall2", 1, 3, 5, 1, 0, 4, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("sub_issue",  1, 3, 5, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        drain(3);

        // producer, nop, consumers: store data via src2 only, then both operands
        applyStimulus("add_r3b", 1, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain(1);
`ifdef FORWARDING_EN
        applyStimulus("sw_gap", 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
`else
        applyStimulus("sw_gap_stall", 1, 1, 3, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("sw_gap_issue", 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        applyStimulus("add_r3c", 1, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain(1);
`ifdef FORWARDING_EN
        applyStimulus("and_gap", 1, 3, 3, 1, 0, 7, 1, 0, 0, 0, 0, 0, 2, 2, 0, 0);
`else
        applyStimulus("and_gap_stall", 1, 3, 3, 1, 0, 7, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("and_gap_issue", 1, 3, 3, 1, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

        // writes to r0 never create a dependency
        applyStimulus("wr_r0", 1, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("rd_r0", 1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain(3);

        // lw r2 then add r6,r2,r2
        applyStimulus("lw_r2", 1, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
        applyStimulus("add_lu_stall", 1, 2, 2, 1, 0, 6, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("add_lu_issue", 1, 2, 2, 1, 0, 6, 1, 0, 0, 0, 0, 0, 2, 2, 0, 0);
`else
        applyStimulus("add_lu_stall1", 1, 2, 2, 1, 0, 6, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("add_lu_stall2", 1, 2, 2, 1, 0, 6, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("add_lu_issue",  1, 2, 2, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        drain(3);

        // lw r2 then a store of r2
        applyStimulus("lw_r2b", 1, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FORWARDING_EN
        applyStimulus("sw_lu_stall", 1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("sw_lu_issue", 1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
`else
        applyStimulus("sw_lu_stall1", 1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("sw_lu_stall2", 1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus("sw_lu_issue",  1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        drain(3);

        // taken branch coinciding with a load-use; the branch held high in FLUSH is ignored
        applyStimulus("lw_r2c",    1, 1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("br_lu",     1, 2, 2, 1, 0, 6, 1, 0, 1, 0, 1, 1, 0, 0, 0, 2);
        applyStimulus("br_flush2", 1, 9, 9, 1, 0, 8, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus("br_after",  1, 2, 2, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain(3);

        // asynchronous reset in the middle of FLUSH
        applyStimulus("br_rst", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 2);
        @(negedge clk);
        hz.br_taken = 1'b0;
        hz.id_valid = 1'b0;
        #1;
        checkOutput("pre_rst.flush", 2'(hz.flush), 2'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst.flush",    2'(hz.flush),  2'd0);
        checkOutput("mid_rst.bubble",   2'(hz.bubble), 2'd0);
        checkOutput("mid_rst.stall",    2'(hz.stall),  2'd0);
        checkOutput("mid_rst.hz_state", hz.hz_state,   2'd0);
        checkOutput("mid_rst.val1_sel", hz.val1_sel,   2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drain(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
